// File: rtl/rxrsp_arb_pkg.sv
// Shared types and constants for the RXRSP response arbiter and related channel arbiters.
package rxrsp_arb_pkg;

  // Default width of the per-source accepted-flit counters.
  localparam int RXRSP_ARB_CNT_W = 16;

  // Response flit as carried on the RXRSP channel.
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] resp;
    logic [1:0] resp_err;
    logic [7:0] txn_id;
  } rspflit_t;

  // Index width for n sources, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority find-first: returns the first set request at or after ptr,
// wrapping past NUM_REQ-1 to 0. Purely combinational, shared by channel arbiters.
module rr_pick
  import rxrsp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  // Scan offsets from the farthest to the nearest so the nearest set request wins.
  always_comb begin
    int idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        sel = IDX_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rxrsp_arb.sv
// Round-robin scheduler feeding the RXRSP pipe slice from NUM_REQ response sources.
// Zero-latency and unbuffered; the downstream slice provides the register stage.
//
// Handshake: a flit moves on a cycle where out_valid & out_ready are both high
// (flush forces out_valid low). Once out_valid is raised for a source and not
// accepted, the grant is locked to that source and its flit must stay stable
// until accepted or flushed; req_ready[i] mirrors that transfer for source i.
module rxrsp_arb
  import rxrsp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = RXRSP_ARB_CNT_W,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              src_en,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  rspflit_t [NUM_REQ-1:0]          req_flit,
  output logic                            out_valid,
  input  logic                            out_ready,
  output rspflit_t                        out_flit,
  output logic [IDX_W-1:0]                out_src,
  output logic [NUM_REQ-1:0][CNT_W-1:0]   gnt_cnt
);

  logic [IDX_W-1:0]              ptr_q;
  logic                          lock_q;
  logic [IDX_W-1:0]              lock_idx_q;
  logic [NUM_REQ-1:0][CNT_W-1:0] gnt_cnt_q;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   pick_sel;
  logic               pick_any;
  logic [IDX_W-1:0]   sel;
  logic               raw_valid;
  logic               xfer;
  logic               stall;
  logic [IDX_W-1:0]   ptr_nxt;

  assign elig = req_valid & src_en;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // A locked grant ignores the enable mask so a pending flit is never revoked.
  always_comb begin
    sel       = lock_q ? lock_idx_q : pick_sel;
    raw_valid = lock_q ? req_valid[lock_idx_q] : pick_any;
    out_valid = raw_valid & ~flush & ~reset;
    xfer      = out_valid & out_ready;
    stall     = out_valid & ~out_ready;
    ptr_nxt   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
    out_flit  = req_flit[sel];
    out_src   = sel;
  end

  // Accept strobe back to the granted source only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer & (sel == IDX_W'(i));
    end
  end

  // Pointer, lock and counter state; flush outranks transfer and stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      gnt_cnt_q  <= '0;
    end else if (flush) begin
      lock_q <= 1'b0;
    end else if (xfer) begin
      ptr_q  <= ptr_nxt;
      lock_q <= 1'b0;
      if (gnt_cnt_q[sel] != '1) begin
        gnt_cnt_q[sel] <= gnt_cnt_q[sel] + CNT_W'(1);
      end
    end else if (stall) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  assign gnt_cnt = gnt_cnt_q;

  // At most one source may be accepted per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($onehot0(req_ready))
        else $error("rxrsp_arb: req_ready not onehot0: %b", req_ready);
    end
  end

  // A locked grant presents the same flit as the stalled cycle before it.
  assert property (@(posedge clock) disable iff (reset)
                   lock_q |-> (out_flit == $past(out_flit)))
    else $error("rxrsp_arb: out_flit changed while locked");

endmodule

// File: tb/tb_rxrsp_arb.sv
// Directed bench for rxrsp_arb with an expected-transfer queue and an output monitor.
module tb_rxrsp_arb;
  import rxrsp_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 2;
  localparam int FW      = $bits(rspflit_t);

  logic                          clock;
  logic                          reset;
  logic                          flush;
  logic [NUM_REQ-1:0]            src_en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  rspflit_t [NUM_REQ-1:0]        req_flit;
  logic                          out_valid;
  logic                          out_ready;
  rspflit_t                      out_flit;
  logic [IDX_W-1:0]              out_src;
  logic [NUM_REQ-1:0][CNT_W-1:0] gnt_cnt;

  logic [IDX_W+FW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  rxrsp_arb #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .src_en    (src_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_flit  (req_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .out_src   (out_src),
    .gnt_cnt   (gnt_cnt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic rspflit_t mk_flit(input int src, input int tag);
    logic [FW-1:0] v;
    v = FW'(16'hA000 + src * 16'h0100 + tag);
    return rspflit_t'(v);
  endfunction

  // driver tasks
  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic set_flits(input int tag);
    for (int i = 0; i < NUM_REQ; i++) req_flit[i] = mk_flit(i, tag);
  endtask

  task automatic expect_xfer(input int src);
    exp_q.push_back({IDX_W'(src), FW'(req_flit[src])});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    src_en    = '1;
    req_valid = '1;
    out_ready = 1'b1;
    @(negedge clock);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    adv();
    reset     = 1'b0;
    req_valid = '0;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [IDX_W+FW-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got src %0d flit %0h expected no transfer (t=%0t)",
                 out_src, out_flit, $time);
      end else begin
        e = exp_q.pop_front();
        check("xfer_src", 32'(out_src), 32'(e[IDX_W+FW-1:FW]));
        check("xfer_flit", 32'(out_flit), 32'(e[FW-1:0]));
        check("xfer_req_ready", 32'(req_ready), 32'(4'b0001 << e[IDX_W+FW-1:FW]));
      end
    end
  end

  // stimulus
  initial begin
    n_cmp = 0;
    n_err = 0;
    set_flits(0);
    reset = 1'b1; flush = 1'b0; src_en = '0; req_valid = '0; out_ready = 1'b0;
    adv();

    // 1: round robin over all four sources
    do_reset();
    @(negedge clock);
    check("t1_cnt_after_reset", 32'(gnt_cnt), 32'h0);
    adv();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_flits(c + 1);
      expect_xfer(c % 4);
      adv();
    end
    req_valid = '0;
    @(negedge clock);
    check("t1_gnt_cnt", 32'(gnt_cnt), 32'h000000AA);
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    adv();
    req_valid = 4'b1111;
    expect_xfer(0);
    adv();
    req_valid = '0;

    // 2: stall on source 1 then accept, next grant goes to 3
    do_reset();
    set_flits(5);
    req_valid = 4'b1010; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t2_stall_valid", 32'(out_valid), 32'h1);
      check("t2_stall_src", 32'(out_src), 32'h1);
      check("t2_stall_flit", 32'(out_flit), 32'(mk_flit(1, 5)));
      check("t2_stall_ready", 32'(req_ready), 32'h0);
      adv();
    end
    out_ready = 1'b1;
    expect_xfer(1);
    adv();
    set_flits(6);
    expect_xfer(3);
    adv();
    req_valid = '0;

    // 3: src_en cleared while source 2 is locked
    do_reset();
    set_flits(7);
    req_valid = 4'b0100; out_ready = 1'b0;
    adv();
    src_en = 4'b1011;
    @(negedge clock);
    check("t3_lock_valid", 32'(out_valid), 32'h1);
    check("t3_lock_src", 32'(out_src), 32'h2);
    adv();
    out_ready = 1'b1;
    expect_xfer(2);
    adv();
    set_flits(8);
    @(negedge clock);
    check("t3_disabled_valid", 32'(out_valid), 32'h0);
    adv();
    req_valid = '0; src_en = '1;

    // 4: flush while locked on source 0
    do_reset();
    set_flits(9);
    req_valid = 4'b0001; out_ready = 1'b0;
    adv();
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    check("t4_flush_valid", 32'(out_valid), 32'h0);
    check("t4_flush_ready", 32'(req_ready), 32'h0);
    adv();
    flush = 1'b0; req_valid = 4'b1111; src_en = 4'b1110;
    @(negedge clock);
    check("t4_cnt_unchanged", 32'(gnt_cnt), 32'h0);
    expect_xfer(1);
    adv();
    req_valid = '0; src_en = '1;

    // 5: counter saturation with CNT_W=2
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_flits(16 + c);
      expect_xfer(0);
      @(negedge clock);
      check("t5_cnt0", 32'(gnt_cnt[0]), 32'((c > 3) ? 3 : c));
      adv();
    end
    req_valid = '0;
    @(negedge clock);
    check("t5_cnt0_sat", 32'(gnt_cnt[0]), 32'h3);
    adv();

    // 6: reset while source 3 is locked
    do_reset();
    set_flits(32);
    req_valid = 4'b0001; out_ready = 1'b1;
    expect_xfer(0);
    adv();
    req_valid = 4'b1000; out_ready = 1'b0;
    adv();
    reset = 1'b1; req_valid = 4'b1001; out_ready = 1'b1;
    @(negedge clock);
    check("t6_reset_valid", 32'(out_valid), 32'h0);
    check("t6_reset_ready", 32'(req_ready), 32'h0);
    adv();
    reset = 1'b0;
    @(negedge clock);
    check("t6_cnt_cleared", 32'(gnt_cnt), 32'h0);
    expect_xfer(0);
    adv();
    req_valid = '0;

    // final report
    adv();
    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
